frogger_game_ctrl: RTL and testbench
====================================

# frogger_game_ctrl

Game-sequencing controller for the Frogger VGA design. Owns the frog position, lives, score and game state, and gates lane-car motion. It sits between the switch inputs and the renderer/car-movement blocks, and advances all game state once per video frame on a frame-tick strobe from the VGA timing logic.

## Interface
Parameters:
- STEP, 16: frog move distance in pixels per accepted press.
- START_X, 312: frog spawn X (pixels).
- START_Y, 464: frog spawn Y (pixels); bottom row.
- MAX_X, 624: largest legal frog X (640 - 16).
- GOAL_Y, 16: frog Y strictly below this value is a crossing.
- HIT_FRAMES, 60: frames held in HIT before respawn.

Ports:
- i_Clk  in  1  pixel clock; one clock domain.
- i_Rst_L  in  1  reset; synchronous, active-low.
- i_Frame_Tick  in  1  one-cycle pulse per frame, at the start of vertical blanking.
- i_Btn_Up / i_Btn_Down / i_Btn_Left / i_Btn_Right  in  1 each  debounced, level-high switches.
- i_Collision  in  1  frog/car pixel overlap from the renderer; level, valid any cycle.
- o_Frog_X  out  10  frog X.
- o_Frog_Y  out  10  frog Y.
- o_Lives  out  2  remaining lives.
- o_Score  out  8  completed crossings, saturating at 255.
- o_State  out  3  current state encoding.
- o_Car_En  out  1  high when cars may move.
- o_Car_Speed  out  3  lane speed multiplier.

## Operation
- States: ATTRACT(0), PLAY(1), HIT(2), WIN(3), OVER(4).
- Press detection: rising edge per button, registered. Only one move is pending at a time: the first press since the last tick is kept and later presses are dropped. Same-cycle presses resolve Up > Down > Left > Right.
- ATTRACT: frog at spawn, cars enabled. Any press goes to PLAY on the next tick, with lives = 3 and score = 0; that press is not applied as a move.
- PLAY, on each tick:
  - Apply the pending move.
  - Up: Y − STEP, but not below 0. Down: Y + STEP, clamped to START_Y. Left/Right: X ± STEP, clamped to 0..MAX_X.
- Collision: a sticky flag is set on any cycle where i_Collision = 1 in PLAY. At the tick, the flag OR the current i_Collision means a hit. A hit goes to HIT and the move is discarded. The flag clears on every tick.
- Crossing: post-move Y < GOAL_Y goes to WIN; score +1, saturating.
- Same tick with both hit and crossing: hit wins.
- HIT: cars frozen (o_Car_En = 0) and frog frozen for HIT_FRAMES ticks. Then lives − 1.
  - If lives becomes 0: go to OVER.
  - Otherwise: respawn and go to PLAY.
- WIN: one frame; frog respawns at the next tick, then PLAY.
- OVER: cars frozen; any press goes to ATTRACT at the next tick.
- Presses and collisions arriving in non-PLAY states are discarded (not queued).

## Timing
- All outputs are registered. Position, lives, score and state update in the cycle after i_Frame_Tick is sampled high.
- Press-to-move latency: at most one frame plus one cycle.
- Reset values: o_Frog_X = START_X, o_Frog_Y = START_Y, o_Lives = 3, o_Score = 0, o_State = ATTRACT, o_Car_En = 1, o_Car_Speed = 1.
- Reset asserted mid-frame or mid-HIT clears every counter, the pending move and the collision flag on that edge.
- HIT frame counter: 6-bit, counts ticks; the exit decision is taken on the HIT_FRAMES-th tick.
- Back-to-back ticks (degenerate stimulus) are legal; each is processed independently.

## Configuration
- FROGGER_SPEEDUP_EN defined:
  - o_Car_Speed = 1 + min(score/4, 6).
  - Resets to 1 on entry to PLAY from ATTRACT.
- Undefined: o_Car_Speed is constant 1 and no divider logic is generated.

## Structure
- Shared package frogger_pkg holds:
  - state enum and its encodings;
  - screen limits 640/480, sprite size 16, spawn coordinates;
  - lives constant 3.
- Sub-module frogger_btn_edge: four-bit rising-edge detector with priority encode, outputting a one-hot move request. The car-movement and renderer blocks import the same package.

## Test plan
- Reset, then press Up for 3 frames, one press per frame → after 3 ticks, Y = 416, X = 312, state PLAY.
- Press Left 20 times from X = 312 → X steps 296, 280, …, saturates at 0; no wrap to 1008.
- Pulse i_Collision for 1 cycle mid-frame in PLAY → HIT at the next tick, o_Car_En = 0; after 60 ticks, lives = 2 and frog at (312, 464).
- Frog at Y = 16 with Up pending and i_Collision high at the same tick → HIT, score unchanged. Repeat without collision → WIN, score = 1, respawn next tick.
- Three hits → OVER with lives = 0. A press → ATTRACT. A press → PLAY with lives = 3, score = 0.
- With FROGGER_SPEEDUP_EN defined: 8 crossings → o_Car_Speed = 3. Reset low mid-HIT → all reset values on the next edge.

Source files
------------

// File: rtl/frogger_pkg.sv
// frogger_pkg: definitions shared by the Frogger game controller, car-movement
// and renderer blocks.
//   state_e          game state encodings (ATTRACT..OVER)
//   SCREEN_W/H       visible screen size in pixels
//   SPRITE_SZ        frog / car sprite edge in pixels
//   SPAWN_X/Y        frog spawn point (bottom row, horizontally centred)
//   LIVES_INIT       lives at the start of a game
//   MV_*             bit positions of the one-hot move request {Up,Down,Left,Right}
package frogger_pkg;

  typedef enum logic [2:0] {
    ST_ATTRACT = 3'd0,
    ST_PLAY    = 3'd1,
    ST_HIT     = 3'd2,
    ST_WIN     = 3'd3,
    ST_OVER    = 3'd4
  } state_e;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int SPRITE_SZ = 16;
  localparam int SPAWN_X   = SCREEN_W / 2 - SPRITE_SZ / 2;
  localparam int SPAWN_Y   = SCREEN_H - SPRITE_SZ;

  localparam logic [1:0] LIVES_INIT = 2'd3;

  localparam int MV_UP    = 3;
  localparam int MV_DOWN  = 2;
  localparam int MV_LEFT  = 1;
  localparam int MV_RIGHT = 0;

endpackage

// File: rtl/frogger_game_ctrl_if.sv
// frogger_game_ctrl_if: frame strobe, player/renderer inputs and game-state
// outputs of the Frogger game controller.
//   master: the controller (samples i_*, drives o_*)
//   slave : the surrounding VGA/switch logic (drives i_*, samples o_*)
interface frogger_game_ctrl_if;

  logic       i_Frame_Tick;
  logic       i_Btn_Up;
  logic       i_Btn_Down;
  logic       i_Btn_Left;
  logic       i_Btn_Right;
  logic       i_Collision;
  logic [9:0] o_Frog_X;
  logic [9:0] o_Frog_Y;
  logic [1:0] o_Lives;
  logic [7:0] o_Score;
  logic [2:0] o_State;
  logic       o_Car_En;
  logic [2:0] o_Car_Speed;

  modport master (
    input  i_Frame_Tick, i_Btn_Up, i_Btn_Down, i_Btn_Left, i_Btn_Right, i_Collision,
    output o_Frog_X, o_Frog_Y, o_Lives, o_Score, o_State, o_Car_En, o_Car_Speed
  );

  modport slave (
    output i_Frame_Tick, i_Btn_Up, i_Btn_Down, i_Btn_Left, i_Btn_Right, i_Collision,
    input  o_Frog_X, o_Frog_Y, o_Lives, o_Score, o_State, o_Car_En, o_Car_Speed
  );

endinterface

// File: rtl/frogger_btn_edge.sv
// frogger_btn_edge: rising-edge detector for the four direction switches with
// priority encode Up > Down > Left > Right.
//   i_Clk    pixel clock
//   i_Rst_L  synchronous active-low reset
//   i_Btn    {Up, Down, Left, Right} debounced levels
//   o_Move   registered one-hot move request, high for one cycle per press
module frogger_btn_edge
  import frogger_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [3:0] i_Btn,
  output logic [3:0] o_Move
);

  logic [3:0] btn_p0;
  logic [3:0] rise;
  logic [3:0] pick;

  always_comb begin
    rise = i_Btn & ~btn_p0;
    pick = '0;
    if (rise[MV_UP])         pick[MV_UP]    = 1'b1;
    else if (rise[MV_DOWN])  pick[MV_DOWN]  = 1'b1;
    else if (rise[MV_LEFT])  pick[MV_LEFT]  = 1'b1;
    else if (rise[MV_RIGHT]) pick[MV_RIGHT] = 1'b1;
  end

  // p0 -> p1: previous levels and encoded request
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      btn_p0 <= '0;
      o_Move <= '0;
    end else begin
      btn_p0 <= i_Btn;
      o_Move <= pick;
    end
  end

endmodule

// File: rtl/frogger_game_ctrl.sv
// frogger_game_ctrl: Frogger game sequencer. Owns frog position, lives, score
// and game state; advances once per video frame on i_Frame_Tick.
//   i_Clk    pixel clock (single domain)
//   i_Rst_L  synchronous active-low reset
//   gif      frogger_game_ctrl_if.master: frame tick, buttons, collision in;
//            frog X/Y, lives, score, state, car enable, car speed out
// Build option: FROGGER_SPEEDUP_EN makes o_Car_Speed = 1 + min(score/4, 6);
// without it o_Car_Speed is a constant 1.
module frogger_game_ctrl
  import frogger_pkg::*;
#(
  parameter int STEP       = SPRITE_SZ,
  parameter int START_X    = SPAWN_X,
  parameter int START_Y    = SPAWN_Y,
  parameter int MAX_X      = SCREEN_W - SPRITE_SZ,
  parameter int GOAL_Y     = SPRITE_SZ,
  parameter int HIT_FRAMES = 60
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  frogger_game_ctrl_if.master  gif
);

  localparam logic [9:0] X_HOME   = 10'(START_X);
  localparam logic [9:0] Y_HOME   = 10'(START_Y);
  localparam logic [9:0] X_MAX    = 10'(MAX_X);
  localparam logic [9:0] Y_GOAL   = 10'(GOAL_Y);
  localparam logic [5:0] HIT_LAST = 6'(HIT_FRAMES - 1);

  // Move one STEP toward zero, stopping at 0.
  function automatic logic [9:0] step_dec(input logic [9:0] v);
    logic signed [11:0] d;
    d = $signed({2'b00, v}) - $signed(12'(STEP));
    return (d < 12'sd0) ? 10'd0 : d[9:0];
  endfunction

  // Move one STEP up, stopping at lim.
  function automatic logic [9:0] step_inc(input logic [9:0] v, input logic [9:0] lim);
    logic signed [11:0] s;
    s = $signed({2'b00, v}) + $signed(12'(STEP));
    return (s > $signed({2'b00, lim})) ? lim : s[9:0];
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [3:0] move_p1;

  frogger_btn_edge u_btn_edge (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Btn   ({gif.i_Btn_Up, gif.i_Btn_Down, gif.i_Btn_Left, gif.i_Btn_Right}),
    .o_Move  (move_p1)
  );

  state_e     state;
  logic [9:0] frog_x;
  logic [9:0] frog_y;
  logic [1:0] lives;
  logic [7:0] score;
  logic [5:0] hit_cnt;
  logic       pend_vld;
  logic [3:0] pend_move;
  logic       coll_flag;
  logic       car_en;

  logic [3:0] eff_move;
  logic       any_press;
  logic       hit_now;
  logic       accept;
  logic       start_game;
  logic       crossing;
  logic [7:0] score_inc;
  logic [9:0] nx;
  logic [9:0] ny;

  // A request arriving on the tick cycle itself still counts as the first
  // press of the frame when nothing was pending.
  always_comb begin
    eff_move   = pend_vld ? pend_move : move_p1;
    any_press  = |eff_move;
    hit_now    = coll_flag | gif.i_Collision;
    accept     = (state == ST_ATTRACT) || (state == ST_PLAY) || (state == ST_OVER);
    score_inc  = sat_inc(score);
    nx         = frog_x;
    ny         = frog_y;
    if (eff_move[MV_UP])         ny = step_dec(frog_y);
    else if (eff_move[MV_DOWN])  ny = step_inc(frog_y, Y_HOME);
    else if (eff_move[MV_LEFT])  nx = step_dec(frog_x);
    else if (eff_move[MV_RIGHT]) nx = step_inc(frog_x, X_MAX);
    start_game = (state == ST_ATTRACT) && any_press;
    crossing   = (state == ST_PLAY) && !hit_now && (ny < Y_GOAL);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state     <= ST_ATTRACT;
      frog_x    <= X_HOME;
      frog_y    <= Y_HOME;
      lives     <= LIVES_INIT;
      score     <= '0;
      hit_cnt   <= '0;
      pend_vld  <= 1'b0;
      pend_move <= '0;
      coll_flag <= 1'b0;
      car_en    <= 1'b1;
    end else if (gif.i_Frame_Tick) begin
      pend_vld  <= 1'b0;
      pend_move <= '0;
      coll_flag <= 1'b0;
      case (state)
        ST_ATTRACT: begin
          if (start_game) begin
            state <= ST_PLAY;
            lives <= LIVES_INIT;
            score <= '0;
          end
        end
        ST_PLAY: begin
          if (hit_now) begin
            state   <= ST_HIT;
            hit_cnt <= '0;
            car_en  <= 1'b0;
          end else begin
            frog_x <= nx;
            frog_y <= ny;
            if (crossing) begin
              state <= ST_WIN;
              score <= score_inc;
            end
          end
        end
        ST_HIT: begin
          if (hit_cnt == HIT_LAST) begin
            lives <= lives - 2'd1;
            if (lives == 2'd1) begin
              state <= ST_OVER;
            end else begin
              state  <= ST_PLAY;
              frog_x <= X_HOME;
              frog_y <= Y_HOME;
              car_en <= 1'b1;
            end
          end else begin
            hit_cnt <= hit_cnt + 6'd1;
          end
        end
        ST_WIN: begin
          state  <= ST_PLAY;
          frog_x <= X_HOME;
          frog_y <= Y_HOME;
        end
        ST_OVER: begin
          if (any_press) begin
            state  <= ST_ATTRACT;
            frog_x <= X_HOME;
            frog_y <= Y_HOME;
            car_en <= 1'b1;
          end
        end
        default: begin
          state  <= ST_ATTRACT;
          car_en <= 1'b1;
        end
      endcase
    end else begin
      // Only the first press of a frame is held; HIT/WIN drop presses.
      if (accept && !pend_vld && (|move_p1)) begin
        pend_vld  <= 1'b1;
        pend_move <= move_p1;
      end
      if ((state == ST_PLAY) && gif.i_Collision) coll_flag <= 1'b1;
    end
  end

`ifdef FROGGER_SPEEDUP_EN
  function automatic logic [2:0] speed_of(input logic [7:0] s);
    logic [5:0] q;
    q = s[7:2];
    return (q > 6'd6) ? 3'd7 : 3'(q + 6'd1);
  endfunction

  logic [2:0] car_speed;

  // Tracks score: back to 1 on a new game, re-derived on every crossing.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      car_speed <= 3'd1;
    end else if (gif.i_Frame_Tick && start_game) begin
      car_speed <= 3'd1;
    end else if (gif.i_Frame_Tick && crossing) begin
      car_speed <= speed_of(score_inc);
    end
  end

  assign gif.o_Car_Speed = car_speed;
`else
  assign gif.o_Car_Speed = 3'd1;
`endif

  assign gif.o_Frog_X = frog_x;
  assign gif.o_Frog_Y = frog_y;
  assign gif.o_Lives  = lives;
  assign gif.o_Score  = score;
  assign gif.o_State  = state;
  assign gif.o_Car_En = car_en;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// tb_frogger_game_ctrl: table-driven and directed checks of frogger_game_ctrl,
// followed by random stimulus compared against a frame-level game model.
module tb_frogger_game_ctrl;

  logic clk = 1'b0;
  logic rst_l;
  always #5 clk = ~clk;

  frogger_game_ctrl_if gif ();

  frogger_game_ctrl dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_l),
    .gif     (gif)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] B_UP = 4'b1000;
  localparam logic [3:0] B_DN = 4'b0100;
  localparam logic [3:0] B_LT = 4'b0010;
  localparam logic [3:0] B_RT = 4'b0001;

  typedef struct {
    logic [3:0] btn;
    bit         coll;
    int         nticks;
    int         x;
    int         y;
    int         lives;
    int         score;
    int         state;
    int         car_en;
  } vec_t;

  vec_t vt[12];

  // ---------------- reference model (frame level, integer arithmetic) -------
  int         m_state = 0;
  int         m_x = 312;
  int         m_y = 464;
  int         m_lives = 3;
  int         m_score = 0;
  int         m_hitn = 0;
  bit         m_coll = 1'b0;
  int         m_req = -1;
  int         m_q[$];
  logic [3:0] m_prev = 4'b0;

`ifdef FROGGER_SPEEDUP_EN
  function automatic int m_speed(input int s);
    int q;
    q = s / 4;
    if (q > 6) q = 6;
    return 1 + q;
  endfunction
`else
  function automatic int m_speed(input int s);
    return (s >= 0) ? 1 : 1;
  endfunction
`endif

  task automatic m_respawn();
    m_x = 312;
    m_y = 464;
  endtask

  task automatic model_step();
    logic [3:0] b;
    int first;
    b = {gif.i_Btn_Up, gif.i_Btn_Down, gif.i_Btn_Left, gif.i_Btn_Right};
    if (!rst_l) begin
      m_state = 0; m_respawn(); m_lives = 3; m_score = 0; m_hitn = 0;
      m_coll = 1'b0; m_req = -1; m_q.delete(); m_prev = 4'b0;
      return;
    end
    if (m_req >= 0 && (m_state == 0 || m_state == 1 || m_state == 4)) m_q.push_back(m_req);
    if (gif.i_Frame_Tick) begin
      first = (m_q.size() > 0) ? m_q[0] : -1;
      case (m_state)
        0: if (first >= 0) begin m_state = 1; m_lives = 3; m_score = 0; end
        1: begin
          if (m_coll || gif.i_Collision) begin
            m_state = 2; m_hitn = 0;
          end else begin
            if (first == 0) m_y = (m_y - 16 < 0) ? 0 : m_y - 16;
            if (first == 1) m_y = (m_y + 16 > 464) ? 464 : m_y + 16;
            if (first == 2) m_x = (m_x - 16 < 0) ? 0 : m_x - 16;
            if (first == 3) m_x = (m_x + 16 > 624) ? 624 : m_x + 16;
            if (m_y < 16) begin
              m_state = 3;
              m_score = (m_score < 255) ? m_score + 1 : 255;
            end
          end
        end
        2: begin
          m_hitn++;
          if (m_hitn == 60) begin
            m_lives--;
            if (m_lives == 0) m_state = 4;
            else begin m_state = 1; m_respawn(); end
          end
        end
        3: begin m_state = 1; m_respawn(); end
        default: if (first >= 0) begin m_state = 0; m_respawn(); end
      endcase
      m_q.delete();
      m_coll = 1'b0;
    end else if (m_state == 1 && gif.i_Collision) begin
      m_coll = 1'b1;
    end
    m_req = -1;
    for (int i = 0; i < 4; i++)
      if (b[3-i] && !m_prev[3-i] && m_req < 0) m_req = i;
    m_prev = b;
  endtask

  always @(posedge clk) model_step();

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int x, input int y, input int l,
                         input int s, input int st, input int ce);
    chk({tag, ".x"},      32'(gif.o_Frog_X), x);
    chk({tag, ".y"},      32'(gif.o_Frog_Y), y);
    chk({tag, ".lives"},  32'(gif.o_Lives),  l);
    chk({tag, ".score"},  32'(gif.o_Score),  s);
    chk({tag, ".state"},  32'(gif.o_State),  st);
    chk({tag, ".car_en"}, 32'(gif.o_Car_En), ce);
  endtask

  task automatic set_btn(input logic [3:0] b);
    gif.i_Btn_Up    = b[3];
    gif.i_Btn_Down  = b[2];
    gif.i_Btn_Left  = b[1];
    gif.i_Btn_Right = b[0];
  endtask

  task automatic press(input logic [3:0] b);
    set_btn(b);
    @(negedge clk);
    set_btn(4'b0);
  endtask

  task automatic tick(input bit coll);
    gif.i_Frame_Tick = 1'b1;
    if (coll) gif.i_Collision = 1'b1;
    @(negedge clk);
    gif.i_Frame_Tick = 1'b0;
    gif.i_Collision  = 1'b0;
  endtask

  task automatic step(input logic [3:0] b);
    press(b);
    tick(1'b0);
    @(negedge clk);
  endtask

  task automatic climb(input int n);
    repeat (n) step(B_UP);
  endtask

  task automatic pulse_coll();
    gif.i_Collision = 1'b1;
    @(negedge clk);
    gif.i_Collision = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- test ----------------
  initial begin
    int exp_x;
    int tcnt;
    logic [3:0] rb;

    vt[0]  = '{B_UP,        1'b0, 1,  312, 464, 3, 0, 1, 1};
    vt[1]  = '{B_UP,        1'b0, 1,  312, 448, 3, 0, 1, 1};
    vt[2]  = '{B_UP,        1'b0, 1,  312, 432, 3, 0, 1, 1};
    vt[3]  = '{B_UP,        1'b0, 1,  312, 416, 3, 0, 1, 1};
    vt[4]  = '{B_LT,        1'b0, 1,  296, 416, 3, 0, 1, 1};
    vt[5]  = '{B_RT,        1'b0, 1,  312, 416, 3, 0, 1, 1};
    vt[6]  = '{B_DN,        1'b0, 1,  312, 432, 3, 0, 1, 1};
    vt[7]  = '{B_UP | B_DN, 1'b0, 1,  312, 416, 3, 0, 1, 1};
    vt[8]  = '{B_LT | B_RT, 1'b0, 1,  296, 416, 3, 0, 1, 1};
    vt[9]  = '{4'b0,        1'b1, 1,  296, 416, 3, 0, 2, 0};
    vt[10] = '{B_UP,        1'b0, 59, 296, 416, 3, 0, 2, 0};
    vt[11] = '{4'b0,        1'b0, 1,  312, 464, 2, 0, 1, 1};

    rst_l = 1'b0;
    set_btn(4'b0);
    gif.i_Frame_Tick = 1'b0;
    gif.i_Collision  = 1'b0;
    repeat (3) @(negedge clk);
    chk_all("reset", 312, 464, 3, 0, 0, 1);
    chk("reset.speed", 32'(gif.o_Car_Speed), 1);
    rst_l = 1'b1;

    for (int i = 0; i < 12; i++) begin
      if (vt[i].btn != 4'b0) press(vt[i].btn);
      if (vt[i].coll) begin
        gif.i_Collision = 1'b1;
        @(negedge clk);
        gif.i_Collision = 1'b0;
      end
      for (int t = 0; t < vt[i].nticks; t++) tick(1'b0);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vt[i].x, vt[i].y, vt[i].lives,
              vt[i].score, vt[i].state, vt[i].car_en);
    end

    for (int k = 1; k <= 22; k++) begin
      step(B_LT);
      exp_x = 312 - 16 * k;
      if (exp_x < 0) exp_x = 0;
      chk($sformatf("left_walk%0d", k), 32'(gif.o_Frog_X), exp_x);
    end
    repeat (45) step(B_RT);
    chk("right_clamp", 32'(gif.o_Frog_X), 624);

    climb(28);
    chk("goal_row", 32'(gif.o_Frog_Y), 16);
    press(B_UP);
    tick(1'b1);
    chk_all("hit_beats_win", 624, 16, 2, 0, 2, 0);
    repeat (60) tick(1'b0);
    chk_all("respawn_after_hit", 312, 464, 1, 0, 1, 1);

    climb(28);
    step(B_UP);
    chk_all("win", 312, 0, 1, 1, 3, 1);
    tick(1'b0);
    chk_all("win_respawn", 312, 464, 1, 1, 1, 1);

    pulse_coll();
    tick(1'b0);
    chk_all("third_hit", 312, 464, 1, 1, 2, 0);
    repeat (59) tick(1'b0);
    chk("hit_hold59", 32'(gif.o_State), 2);
    tick(1'b0);
    chk_all("game_over", 312, 464, 0, 1, 4, 0);
    step(B_DN);
    chk_all("over_to_attract", 312, 464, 0, 1, 0, 1);
    step(B_RT);
    chk_all("new_game", 312, 464, 3, 0, 1, 1);
    chk("new_game.speed", 32'(gif.o_Car_Speed), 1);

`ifdef FROGGER_SPEEDUP_EN
    for (int c = 0; c < 8; c++) begin
      climb(29);
      tick(1'b0);
    end
    chk("speedup.score", 32'(gif.o_Score), 8);
    chk("speedup.speed", 32'(gif.o_Car_Speed), 3);
`endif

    step(B_LT);
    pulse_coll();
    tick(1'b0);
    repeat (5) tick(1'b0);
    chk("pre_reset_hit", 32'(gif.o_State), 2);
    set_btn(B_UP);
    gif.i_Collision = 1'b1;
    rst_l = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    set_btn(4'b0);
    gif.i_Collision = 1'b0;
    chk_all("reset_mid_hit", 312, 464, 3, 0, 0, 1);
    chk("reset_mid_hit.speed", 32'(gif.o_Car_Speed), 1);
    @(negedge clk);
    tick(1'b0);
    chk("no_press_after_reset", 32'(gif.o_State), 0);

    // Random phase against the model.
    rst_l = 1'b0;
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    rb = 4'b0;
    tcnt = 3;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      chk("rand.x",      32'(gif.o_Frog_X),    m_x);
      chk("rand.y",      32'(gif.o_Frog_Y),    m_y);
      chk("rand.lives",  32'(gif.o_Lives),     m_lives);
      chk("rand.score",  32'(gif.o_Score),     m_score);
      chk("rand.state",  32'(gif.o_State),     m_state);
      chk("rand.car_en", 32'(gif.o_Car_En),    (m_state == 2 || m_state == 4) ? 0 : 1);
      chk("rand.speed",  32'(gif.o_Car_Speed), m_speed(m_score));
      if ($urandom_range(0, 7) == 0) rb[$urandom_range(0, 3)] ^= 1'b1;
      set_btn(rb);
      gif.i_Collision = ($urandom_range(0, 199) == 0);
      if (tcnt == 0) begin
        gif.i_Frame_Tick = 1'b1;
        tcnt = $urandom_range(0, 5);
      end else begin
        gif.i_Frame_Tick = 1'b0;
        tcnt--;
      end
      rst_l = ($urandom_range(0, 999) != 0);
    end

    set_btn(4'b0);
    gif.i_Frame_Tick = 1'b0;
    gif.i_Collision  = 1'b0;
    rst_l = 1'b1;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
